// File: rtl/rgb_capture.sv
`default_nettype none
// ============================================================================
// Module      : rgb_capture
// Description : Parallel RGB888 video receiver. Samples an external RGB
//               stream (hsync/vsync/de), converts pixels to RGB565 and emits
//               write strobes for port A of the dual-port framebuffer.
//               Tracks pixel/line position, realigns addresses at every de
//               falling edge, drops out-of-window pixels and reports frame
//               completion with a sticky geometry-error flag.
// Ports       : clk          capture clock (source pixel clock)
//               rst          asynchronous reset, active low
//               enable       capture enable, looked at on vsync leading edge
//               rgb_r/g/b    8-bit colour components
//               rgb_hsync    horizontal sync (diagnostics only)
//               rgb_vsync    vertical sync
//               rgb_de       data enable, delimits lines
//               fb_data_out  RGB565 pixel
//               fb_addr      framebuffer write address
//               fb_wr_en     write strobe, one pixel per cycle
//               frame_done   one-cycle pulse on frame close
//               frame_err    geometry error of the closed frame
//               line_cnt     completed active lines of the current frame
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_capture #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_WIDTH = 19,
    parameter bit VSYNC_POL  = 1'b0,
    parameter bit HSYNC_POL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [7:0]            rgb_r,
    input  logic [7:0]            rgb_g,
    input  logic [7:0]            rgb_b,
    input  logic                  rgb_hsync,
    input  logic                  rgb_vsync,
    input  logic                  rgb_de,
    output logic [15:0]           fb_data_out,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic                  fb_wr_en,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [9:0]            line_cnt
);

    localparam int                    c_XW    = $clog2(H_ACTIVE + 1);
    localparam logic [c_XW-1:0]       c_H_X   = c_XW'(H_ACTIVE);
    localparam logic [9:0]            c_V_Y   = 10'(V_ACTIVE);
    localparam logic [ADDR_WIDTH-1:0] c_H_A   = ADDR_WIDTH'(H_ACTIVE);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARMED = 2'd1;
    localparam logic [1:0] c_ST_LINE  = 2'd2;

    // Input sampling stage (only the colour bits that survive RGB565).
    logic [4:0]            r_r;
    logic [5:0]            r_g;
    logic [4:0]            r_b;
    logic                  r_hs;
    logic                  r_vs;
    logic                  r_vs_d;
    logic                  r_de;
    logic                  r_en;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_XW-1:0]       r_x;
    logic [9:0]            r_y;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_line_base;
    logic                  r_err;

    logic w_vs_lead;
    logic w_capturing;
    logic w_pix;
    logic w_x_ok;
    logic w_y_ok;
    logic w_wr;
    logic w_de_fall;
    logic w_close;
    logic w_unused_lsbs;

    // Truncated colour LSBs are intentionally discarded.
    assign w_unused_lsbs = ^{rgb_r[2:0], rgb_g[1:0], rgb_b[2:0]};

    assign w_vs_lead   = (r_vs == VSYNC_POL) && (r_vs_d != VSYNC_POL);
    assign w_capturing = (r_state != c_ST_IDLE);
    // vsync leading edge takes precedence over a coincident de pixel.
    assign w_pix       = r_de && w_capturing && !w_vs_lead;
    assign w_x_ok      = (r_x < c_H_X);
    assign w_y_ok      = (r_y < c_V_Y);
    assign w_wr        = w_pix && w_x_ok && w_y_ok;
    // In LINE the previous sampled de was 1, so de=0 here is a falling edge.
    assign w_de_fall   = (r_state == c_ST_LINE) && !r_de && !w_vs_lead;
    assign w_close     = w_vs_lead && w_capturing;
    assign line_cnt    = r_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_vs_lead && r_en) begin
                    w_state_nxt = c_ST_ARMED;
                end
            end
            c_ST_ARMED: begin
                if (w_vs_lead) begin
                    w_state_nxt = r_en ? c_ST_ARMED : c_ST_IDLE;
                end else if (r_de) begin
                    w_state_nxt = c_ST_LINE;
                end
            end
            c_ST_LINE: begin
                if (w_vs_lead) begin
                    w_state_nxt = r_en ? c_ST_ARMED : c_ST_IDLE;
                end else if (!r_de) begin
                    w_state_nxt = c_ST_ARMED;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r         <= '0;
            r_g         <= '0;
            r_b         <= '0;
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            r_vs_d      <= 1'b0;
            r_de        <= 1'b0;
            r_en        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_addr      <= '0;
            r_line_base <= '0;
            r_err       <= 1'b0;
            fb_data_out <= '0;
            fb_addr     <= '0;
            fb_wr_en    <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_r    <= rgb_r[7:3];
            r_g    <= rgb_g[7:2];
            r_b    <= rgb_b[7:3];
            r_hs   <= rgb_hsync;
            r_vs   <= rgb_vsync;
            r_vs_d <= r_vs;
            r_de   <= rgb_de;
            r_en   <= enable;

            fb_wr_en   <= w_wr;
            frame_done <= w_close;
            if (w_wr) begin
                fb_data_out <= {r_r, r_g, r_b};
                fb_addr     <= r_addr;
            end
            if (w_close) begin
                // A frame cut off mid-line is always a geometry error.
                frame_err <= r_err || (r_y != c_V_Y) || (r_state == c_ST_LINE);
            end

            if (w_vs_lead) begin
                r_x         <= '0;
                r_y         <= '0;
                r_addr      <= '0;
                r_line_base <= '0;
                r_err       <= 1'b0;
            end else begin
                if (w_pix) begin
                    if (w_x_ok) begin
                        r_x <= r_x + c_XW'(1);
                    end
                    if (w_wr) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                    // Long line, extra line or hsync inside the active window.
                    if (!w_x_ok || !w_y_ok || (r_hs == HSYNC_POL)) begin
                        r_err <= 1'b1;
                    end
                end
                if (w_de_fall) begin
                    r_x <= '0;
                    if (w_x_ok) begin
                        r_err <= 1'b1;
                    end
                    // Line base steps by H_ACTIVE so the next line starts at
                    // (y+1)*H_ACTIVE regardless of how many pixels arrived.
                    if (w_y_ok) begin
                        r_y         <= r_y + 10'd1;
                        r_line_base <= r_line_base + c_H_A;
                        r_addr      <= r_line_base + c_H_A;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgb_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_capture
// Description : Self-checking bench for rgb_capture, reduced frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_capture;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [7:0]    rgb_r, rgb_g, rgb_b;
    logic          rgb_hsync, rgb_vsync, rgb_de;
    logic [15:0]   fb_data_out;
    logic [AW-1:0] fb_addr;
    logic          fb_wr_en, frame_done, frame_err;
    logic [9:0]    line_cnt;

    rgb_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW), .VSYNC_POL(1'b0), .HSYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .rgb_hsync(rgb_hsync), .rgb_vsync(rgb_vsync), .rgb_de(rgb_de),
        .fb_data_out(fb_data_out), .fb_addr(fb_addr), .fb_wr_en(fb_wr_en),
        .frame_done(frame_done), .frame_err(frame_err), .line_cnt(line_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    typedef struct {
        int nlines;
        int odd_line;
        int odd_len;
        int glitch_line;
        int color;
        bit exp_err;
        int exp_lines;
    } frame_t;

    wr_t exp_q[$];
    bit  exp_f[$];
    bit  sb_on = 1'b1;
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] conv(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

    // Scoreboard: writes and frame closes are compared in arrival order.
    always @(negedge clk) begin
        if (rst && sb_on) begin
            if (fb_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h expected no write", fb_addr);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(fb_addr), 32'(e.addr));
                    check("wr_data", 32'(fb_data_out), 32'(e.data));
                end
            end
            if (frame_done) begin
                if (exp_f.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: got 1 expected 0");
                end else begin
                    bit fe;
                    fe = exp_f.pop_front();
                    check("frame_err", 32'(frame_err), 32'(fe));
                end
            end
        end
    end

    task automatic cyc(input bit de, input bit hs, input bit vs, input logic [23:0] rgb);
        rgb_de    = de;
        rgb_hsync = hs;
        rgb_vsync = vs;
        {rgb_r, rgb_g, rgb_b} = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 24'h0);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 24'h0);
    endtask

    task automatic line(input int l, input int len, input int color, input int glitch_pix, input bit push);
        for (int x = 0; x < len; x++) begin
            logic [23:0] rgb;
            wr_t         w;
            rgb = (color < 0) ? 24'($urandom) : 24'(color);
            if (push && x < H && l < V) begin
                w.addr = AW'(l * H + x);
                w.data = conv(rgb);
                exp_q.push_back(w);
            end
            cyc(1'b1, (x == glitch_pix) ? 1'b0 : 1'b1, 1'b1, rgb);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 24'h0);
        repeat (2) cyc(1'b0, 1'b1, 1'b1, 24'h0);
    endtask

    initial begin
        frame_t ft[6];
        ft[0] = '{V,     -1, 0,      -1, 'hFF00FF, 1'b0, V};
        ft[1] = '{V,      0, H + 5,  -1, -1,       1'b1, V};
        ft[2] = '{V,      3, H - 10, -1, -1,       1'b1, V};
        ft[3] = '{V + 2, -1, 0,      -1, -1,       1'b1, V};
        ft[4] = '{V,     -1, 0,       1, -1,       1'b1, V};
        ft[5] = '{V - 1, -1, 0,      -1, 'h123456, 1'b1, V - 1};

        rst = 1'b0; enable = 1'b1;
        rgb_de = 1'b0; rgb_hsync = 1'b1; rgb_vsync = 1'b1;
        {rgb_r, rgb_g, rgb_b} = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(fb_wr_en), 32'd0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_data", 32'(fb_data_out), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);
        rst = 1'b1;
        repeat (2) cyc(1'b0, 1'b1, 1'b1, 24'h0);

        // First vsync only arms; no frame_done expected.
        vsync_pulse();

        for (int f = 0; f < 6; f++) begin
            for (int l = 0; l < ft[f].nlines; l++) begin
                line(l, (l == ft[f].odd_line) ? ft[f].odd_len : H, ft[f].color,
                     (l == ft[f].glitch_line) ? 2 : -1, 1'b1);
            end
            check("line_cnt", 32'(line_cnt), 32'(ft[f].exp_lines));
            exp_f.push_back(ft[f].exp_err);
            vsync_pulse();
        end

        // Two-cycle latency of a single pixel.
        begin
            wr_t w;
            w.addr = '0;
            w.data = 16'h11AA;
            exp_q.push_back(w);
        end
        cyc(1'b1, 1'b1, 1'b1, 24'h123456);
        check("lat_n1_wr_en", 32'(fb_wr_en), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 24'h0);
        check("lat_n2_wr_en", 32'(fb_wr_en), 32'd1);
        check("lat_n2_data", 32'(fb_data_out), 32'h11AA);
        check("lat_n2_addr", 32'(fb_addr), 32'd0);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 24'h0);

        // vsync edge coincident with de: no write, frame closes.
        exp_f.push_back(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 24'hABCDEF);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 24'h0);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 24'h0);
        check("coinc_line_cnt", 32'(line_cnt), 32'd0);

        // enable=0: closes the armed frame, then ignores the next one.
        enable = 1'b0;
        exp_f.push_back(1'b1);
        vsync_pulse();
        line(0, H, -1, -1, 1'b0);
        vsync_pulse();
        enable = 1'b1;

        // Reset in the middle of a line.
        vsync_pulse();
        sb_on = 1'b0;
        repeat (5) cyc(1'b1, 1'b1, 1'b1, 24'h00FF00);
        check("pre_rst_wr_en", 32'(fb_wr_en), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_wr_en", 32'(fb_wr_en), 32'd0);
        check("midrst_addr", 32'(fb_addr), 32'd0);
        check("midrst_line_cnt", 32'(line_cnt), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 24'h0);
        rst = 1'b1;
        exp_q.delete();
        sb_on = 1'b1;
        line(0, H, -1, -1, 1'b0);
        vsync_pulse();
        line(0, H, -1, -1, 1'b1);
        check("post_rst_line_cnt", 32'(line_cnt), 32'd1);
        enable = 1'b0;
        exp_f.push_back(1'b1);
        vsync_pulse();
        repeat (5) cyc(1'b0, 1'b1, 1'b1, 24'h0);

        check("writes_drained", 32'(exp_q.size()), 32'd0);
        check("frames_drained", 32'(exp_f.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgb_capture.md
Name: rgb_capture

Overview:
- Parallel RGB video receiver, the inverse of the framebuffer-to-panel RGB output path.
- Samples an external RGB888 stream with hsync/vsync/de, converts each pixel to RGB565, and emits framebuffer write strobes (data, address, enable) for port A of the dual-port framebuffer RAM.
- Tracks pixel and line position, re-aligns to line boundaries, discards out-of-window pixels, and reports per-frame completion and error status.

Parameters:
- H_ACTIVE, 800: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- ADDR_WIDTH, 19: framebuffer address width.
- VSYNC_POL, 0: vsync active level (0 = active-low).
- HSYNC_POL, 0: hsync active level (0 = active-low).

Ports:
- clk  input  1  capture clock; equals the source pixel clock, all inputs synchronous to it.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  capture enable, sampled only at vsync leading edge.
- rgb_r  input  8  red component.
- rgb_g  input  8  green component.
- rgb_b  input  8  blue component.
- rgb_hsync  input  1  horizontal sync.
- rgb_vsync  input  1  vertical sync.
- rgb_de  input  1  data enable.
- fb_data_out  output  16  RGB565 pixel.
- fb_addr  output  ADDR_WIDTH  framebuffer write address.
- fb_wr_en  output  1  write strobe, one pixel per asserted cycle.
- frame_done  output  1  one-cycle pulse when a captured frame closes.
- frame_err  output  1  valid with frame_done; 1 if the closed frame had any geometry error.
- line_cnt  output  10  completed active lines in the current frame.

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; x, y and address counters 0; error flag cleared; input pipeline registers cleared.
- Input stage: all inputs registered once. Vsync leading edge = registered vsync transitions from inactive to active per VSYNC_POL. hsync is used only for diagnostics (see hsync-during-DE error). Line segmentation is by de.
- Latency: a pixel sampled with de=1 on cycle N produces fb_wr_en=1 on cycle N+2 with its data and address; fixed, no bubbles.
- Conversion: fb_data_out = {r[7:3], g[7:2], b[7:3]}.
- Addressing: fb_addr is a running counter starting at 0 at each frame.
  - Increments by 1 per written pixel.
  - At de falling edge, the counter is set to (y+1)*H_ACTIVE, computed incrementally with a line-base register, no multiplier.
- States:
  - IDLE: no writes. Vsync leading edge with enable=1 -> ARMED (counters cleared). enable=0 -> stay in IDLE.
  - ARMED: wait for de=1 -> LINE.
  - LINE: write while de=1 and x<H_ACTIVE and y<V_ACTIVE.
    - de falls -> ARMED; x=0, y+1, line_cnt+1 if y<V_ACTIVE.
    - Vsync leading edge while in LINE -> close frame with error, then re-arm per enable.
  - Any state except IDLE: vsync leading edge closes the frame.
    - frame_done=1 for one cycle.
    - frame_err = error flag OR (line_cnt != V_ACTIVE).
    - Then counters clear; enable=1 -> ARMED, enable=0 -> IDLE.
- Errors (sticky until frame close), each sets the flag:
  - Long line: pixels with x>=H_ACTIVE are dropped, no write.
  - Short line: de falls with x<H_ACTIVE; the address still realigns to the next line start.
  - Extra lines: de lines with y>=V_ACTIVE are dropped entirely.
  - hsync active while de=1.
- Simultaneous vsync leading edge and de=1 on the same cycle: vsync wins. That pixel is not written, the frame closes, and the pixel is not counted in the new frame.
- line_cnt saturates at V_ACTIVE.
- frame_done is never asserted for a frame started in IDLE; the first vsync after reset only arms capture.
- Reset mid-line: outputs are 0 immediately. After release, no writes occur until the next vsync leading edge with enable=1.

Test Plan:
- Reset, enable=1, vsync edge, then 480 lines of 800 de-cycles with r=0xFF, g=0x00, b=0xFF -> 384000 writes, fb_data_out=0xF81F, addresses 0..383999 contiguous, next vsync edge gives frame_done=1, frame_err=0, line_cnt=480.
- Line 0 has 805 de-cycles -> exactly 800 writes on line 0, line 1 starts at address 800, frame_err=1 at frame close.
- Line 3 has 790 de-cycles -> last write of line 3 at address 3189, first write of line 4 at 3200, frame_err=1.
- 482 active lines -> lines 480 and 481 produce no writes, line_cnt=480, frame_err=1.
- Pixel with value 0x123456 sampled with de=1 on cycle N -> fb_wr_en=1 at cycle N+2, fb_data_out=0x11AA, fb_addr=0; then vsync edge coincident with de=1 gives no write and a frame_done pulse.
- enable=0 at vsync edge -> no writes and no frame_done for that frame.
- Assert rst low mid-line -> fb_wr_en=0 the same cycle; after release, writes resume only after the next vsync edge, starting at address 0.
